// File: rtl/sme_pkg.sv
// Shared types and character constants for the parametrised string-matching engine.
package sme_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StLdStr,
        StLdPat,
        StSearch,
        StDone
    } state_t;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational match test of the decoded pattern against the string window around position p.
module sme_window_cmp
    import sme_pkg::*;
#(
    parameter int unsigned PAT_MAX = 16,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned CNT_W   = 7,
    parameter int unsigned K_W     = 5
) (
    input  logic [PAT_MAX+1:0][7:0] i_win,
    input  logic [PAT_MAX-1:0][7:0] i_core,
    input  logic [K_W-1:0]          i_k,
    input  logic                    i_a_head,
    input  logic                    i_a_tail,
    input  logic [IDX_W-1:0]        i_pos,
    input  logic [CNT_W-1:0]        i_slen,
    output logic                    o_hit
);

    logic       w_fits;
    logic       w_core_ok;
    logic       w_head_ok;
    logic       w_tail_ok;
    logic       w_at_end;
    logic [7:0] w_tail_ch;

    // i_win[0] is str[p-1]; i_win[j+1] is str[p+j].
    always_comb begin
        w_core_ok = 1'b1;
        w_tail_ch = 8'h00;
        for (int j = 0; j < PAT_MAX; j++) begin
            if (j < int'(i_k) && i_core[j] != CH_DOT && i_core[j] != i_win[j+1]) begin
                w_core_ok = 1'b0;
            end
        end
        for (int j = 0; j <= PAT_MAX; j++) begin
            if (j == int'(i_k)) begin
                w_tail_ch = i_win[j+1];
            end
        end
        w_fits    = (int'(i_pos) + int'(i_k)) <= int'(i_slen);
        w_at_end  = (int'(i_pos) + int'(i_k)) == int'(i_slen);
        w_head_ok = !i_a_head || (i_pos == '0) || (i_win[0] == CH_SPACE);
        w_tail_ok = !i_a_tail || w_at_end || (w_tail_ch == CH_SPACE);
        o_hit     = w_fits && w_core_ok && w_head_ok && w_tail_ok;
    end

endmodule

// File: rtl/sme_param.sv
// String-matching engine: byte-serial string/pattern load, one-position-per-cycle search.
module sme_param
    import sme_pkg::*;
#(
    parameter int unsigned STR_MAX = 64,
    parameter int unsigned PAT_MAX = 16,
    parameter int unsigned IDX_W   = $clog2(STR_MAX),
    parameter int unsigned CNT_W   = $clog2(STR_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index,
    output logic [CNT_W-1:0] match_count,
    output logic             ovf
);

    localparam int unsigned PLEN_W = $clog2(PAT_MAX + 1);
    localparam int unsigned PIDX_W = $clog2(PAT_MAX);
    localparam int unsigned WIN_N  = PAT_MAX + 2;

    state_t                  r_state;
    state_t                  w_state_d;
    logic [7:0]              r_str [STR_MAX];
    logic [7:0]              r_pat [PAT_MAX];
    logic [CNT_W-1:0]        r_slen;
    logic [PLEN_W-1:0]       r_plen;
    logic [PAT_MAX-1:0][7:0] r_core;
    logic [PLEN_W-1:0]       r_k;
    logic                    r_a_head;
    logic                    r_a_tail;
    logic [IDX_W-1:0]        r_pos;
    logic                    r_valid;
    logic                    r_match;
    logic [IDX_W-1:0]        r_index;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;

    logic                    w_str_first;
    logic                    w_str_we;
    logic                    w_str_room;
    logic [IDX_W-1:0]        w_str_addr;
    logic                    w_pat_first;
    logic                    w_pat_we;
    logic                    w_pat_room;
    logic [PIDX_W-1:0]       w_pat_addr;
    logic                    w_start;
    logic                    w_last;
    logic                    w_head;
    logic                    w_tail;
    logic [PLEN_W-1:0]       w_k;
    logic [PAT_MAX-1:0][7:0] w_core;
    logic [WIN_N-1:0][7:0]   w_win;
    logic                    w_hit;

    // A simultaneous isstring always takes priority over the pattern byte.
    always_comb begin
        w_str_first = (r_state == StIdle) && isstring;
        w_str_we    = isstring && ((r_state == StIdle) || (r_state == StLdStr));
        w_pat_first = (r_state == StIdle) && ispattern && !isstring;
        w_pat_we    = ispattern && !isstring && ((r_state == StIdle) || (r_state == StLdPat));
        w_str_room  = w_str_first || (r_slen < CNT_W'(STR_MAX));
        w_pat_room  = w_pat_first || (r_plen < PLEN_W'(PAT_MAX));
        w_str_addr  = w_str_first ? '0 : r_slen[IDX_W-1:0];
        w_pat_addr  = w_pat_first ? '0 : r_plen[PIDX_W-1:0];
        w_start     = (r_state == StLdPat) && !ispattern;
        w_last      = (CNT_W'(r_pos) + CNT_W'(1)) >= r_slen;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (isstring) begin
                    w_state_d = StLdStr;
                end else if (ispattern) begin
                    w_state_d = StLdPat;
                end
            end
            StLdStr:  if (!isstring) w_state_d = StIdle;
            StLdPat:  if (!ispattern) w_state_d = StSearch;
            StSearch: if (w_last) w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Strip the optional anchors; the core is the pattern shifted past a leading caret.
    always_comb begin
        w_head = (r_plen != '0) && (r_pat[0] == CH_CARET);
        w_tail = 1'b0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (PLEN_W'(i) == (r_plen - PLEN_W'(1)) && (r_plen > PLEN_W'(w_head))
                    && (r_pat[i] == CH_DOLLAR)) begin
                w_tail = 1'b1;
            end
        end
        w_k = r_plen - PLEN_W'(w_head) - PLEN_W'(w_tail);
        for (int j = 0; j < PAT_MAX; j++) begin
            w_core[j] = r_pat[j];
        end
        if (w_head) begin
            for (int j = 0; j < PAT_MAX - 1; j++) begin
                w_core[j] = r_pat[j+1];
            end
            w_core[PAT_MAX-1] = 8'h00;
        end
    end

    always_comb begin
        for (int i = 0; i < WIN_N; i++) begin
            w_win[i] = 8'h00;
            for (int s = 0; s < STR_MAX; s++) begin
                if (s == int'(r_pos) + i - 1) begin
                    w_win[i] = r_str[s];
                end
            end
        end
    end

    sme_window_cmp #(
        .PAT_MAX (PAT_MAX),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W),
        .K_W     (PLEN_W)
    ) u_cmp (
        .i_win    (w_win),
        .i_core   (r_core),
        .i_k      (r_k),
        .i_a_head (r_a_head),
        .i_a_tail (r_a_tail),
        .i_pos    (r_pos),
        .i_slen   (r_slen),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk) begin
        if (w_str_we && w_str_room) begin
            r_str[w_str_addr] <= chardata;
        end
        if (w_pat_we && w_pat_room) begin
            r_pat[w_pat_addr] <= chardata;
        end
        if (w_start) begin
            r_core   <= w_core;
            r_k      <= w_k;
            r_a_head <= w_head;
            r_a_tail <= w_tail;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_slen  <= '0;
            r_plen  <= '0;
            r_pos   <= '0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_index <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_valid <= (r_state == StDone);
            if (w_str_we) begin
                if (w_str_first) begin
                    r_slen <= CNT_W'(1);
                    r_ovf  <= 1'b0;
                end else if (w_str_room) begin
                    r_slen <= r_slen + CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_pat_we) begin
                if (w_pat_first) begin
                    r_plen <= PLEN_W'(1);
                end else if (w_pat_room) begin
                    r_plen <= r_plen + PLEN_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_start) begin
                r_pos   <= '0;
                r_match <= 1'b0;
                r_index <= '0;
                r_count <= '0;
            end else if (r_state == StSearch) begin
                if (w_hit) begin
                    if (!r_match) begin
                        r_match <= 1'b1;
                        r_index <= r_pos;
                    end
                    r_count <= r_count + CNT_W'(1);
                end
                r_pos <= r_pos + IDX_W'(1);
            end
        end
    end

    assign valid       = r_valid;
    assign match       = r_match;
    assign match_index = r_index;
    assign match_count = r_count;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_sme_param.sv
// Self-checking bench for sme_param: directed scenarios plus randomized strings/patterns.
module tb_sme_param;

    localparam int STR_MAX = 64;
    localparam int PAT_MAX = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [5:0] match_index;
    logic [6:0] match_count;
    logic       ovf;

    sme_param #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .match_count (match_count),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: string/pattern as the engine holds them after truncation.
    logic [7:0] m_str[$];
    logic [7:0] m_pat[$];
    bit         m_ovf = 1'b0;
    bit         m_exp_m;
    int         m_exp_i;
    int         m_exp_c;

    bit chk_en   = 1'b0;
    bit pending  = 1'b0;
    int exp_cyc  = 0;
    bit hold_chk = 1'b0;
    bit hold_m   = 1'b0;
    int hold_i   = 0;
    int hold_c   = 0;
    int last_e_cyc     = 0;
    int last_valid_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_search();
        logic [7:0] core[$];
        bit head;
        bit tail;
        bit ok;
        int k;
        int n;
        int sl;
        core = m_pat;
        head = (core.size() > 0) && (core[0] == 8'h5E);
        if (head) void'(core.pop_front());
        tail = (core.size() > 0) && (core[core.size()-1] == 8'h24);
        if (tail) void'(core.pop_back());
        k  = core.size();
        sl = m_str.size();
        n  = (sl == 0) ? 1 : sl;
        m_exp_m = 1'b0;
        m_exp_i = 0;
        m_exp_c = 0;
        for (int p = 0; p < n; p++) begin
            ok = (p + k <= sl);
            if (ok) begin
                for (int j = 0; j < k; j++) begin
                    if (core[j] != 8'h2E && m_str[p+j] != core[j]) ok = 1'b0;
                end
                if (head && !(p == 0 || m_str[p-1] == 8'h20)) ok = 1'b0;
                if (tail && !(p + k == sl || m_str[p+k] == 8'h20)) ok = 1'b0;
            end
            if (ok) begin
                if (!m_exp_m) begin
                    m_exp_m = 1'b1;
                    m_exp_i = p;
                end
                m_exp_c++;
            end
        end
    endfunction

    // Compare process: valid every cycle, results on valid and while held, ovf always.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) last_valid_cyc = cyc;
            if (chk_en) begin
                if (pending && cyc == exp_cyc) begin
                    chk("valid_pulse", int'(valid), 1);
                    chk("match", int'(match), int'(m_exp_m));
                    chk("match_index", int'(match_index), m_exp_i);
                    chk("match_count", int'(match_count), m_exp_c);
                    hold_m   = m_exp_m;
                    hold_i   = m_exp_i;
                    hold_c   = m_exp_c;
                    hold_chk = 1'b1;
                    pending  = 1'b0;
                end else begin
                    chk("valid_quiet", int'(valid), 0);
                    if (hold_chk) begin
                        chk("hold_match", int'(match), int'(hold_m));
                        chk("hold_index", int'(match_index), hold_i);
                        chk("hold_count", int'(match_count), hold_c);
                    end
                end
                chk("ovf", int'(ovf), int'(m_ovf));
            end
        end
    end

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            chardata = s[i];
            isstring = 1'b1;
            @(posedge clk);
            if (i == 0) begin
                m_str.delete();
                m_ovf = 1'b0;
            end
            if (m_str.size() < STR_MAX) m_str.push_back(s[i]);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        isstring = 1'b0;
        chardata = 8'h00;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        pending  = 1'b0;
        hold_chk = 1'b1;
        hold_m   = 1'b0;
        hold_i   = 0;
        hold_c   = 0;
        m_ovf    = 1'b0;
        m_str.delete();
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_pattern(input string s, input int rst_after, input bit garbage);
        int n;
        int budget;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            chardata  = s[i];
            ispattern = 1'b1;
            @(posedge clk);
            if (i == 0) m_pat.delete();
            if (m_pat.size() < PAT_MAX) m_pat.push_back(s[i]);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        ispattern = 1'b0;
        chardata  = 8'h00;
        model_search();
        n          = (m_str.size() == 0) ? 1 : m_str.size();
        hold_chk   = 1'b0;
        last_e_cyc = cyc + 1;
        if (rst_after > 0) begin
            repeat (rst_after) @(negedge clk);
            apply_reset(1);
            repeat (n + 8) @(negedge clk);
        end else begin
            exp_cyc = cyc + n + 2;
            pending = 1'b1;
            if (garbage) begin
                repeat ((n < 4) ? n : 4) begin
                    @(negedge clk);
                    isstring  = 1'($urandom);
                    ispattern = 1'($urandom);
                    chardata  = 8'($urandom);
                end
                @(negedge clk);
                isstring  = 1'b0;
                ispattern = 1'b0;
                chardata  = 8'h00;
            end
            budget = n + 20;
            while (pending && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (pending) begin
                checks++;
                failures++;
                $display("FAIL valid_timeout: got no valid, expected one at cycle %0d", exp_cyc);
                pending = 1'b0;
            end
        end
    endtask

    // Pins the model to hand-computed results and checks the held DUT outputs against them.
    task automatic lit(input string name, input int em, input int ei, input int ec);
        chk({name, "_model_match"}, int'(m_exp_m), em);
        chk({name, "_model_index"}, m_exp_i, ei);
        chk({name, "_model_count"}, m_exp_c, ec);
        chk({name, "_dut_match"}, int'(match), em);
        chk({name, "_dut_index"}, int'(match_index), ei);
        chk({name, "_dut_count"}, int'(match_count), ec);
    endtask

    initial begin
        string s;
        string p;
        string alpha_s;
        string alpha_p;
        int    len;
        int    r;

        reset     = 1'b1;
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        hold_chk  = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset_valid", int'(valid), 0);
        chk("reset_match", int'(match), 0);
        chk("reset_index", int'(match_index), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_ovf", int'(ovf), 0);

        send_pattern("^$", 0, 1'b0);
        lit("empty_anchors", 1, 0, 1);

        send_string("the cat sat");
        send_pattern("at", 0, 1'b0);
        lit("basic_at", 1, 5, 2);
        chk("basic_ovf", int'(ovf), 0);
        send_pattern("^sat", 0, 1'b0);
        lit("head_sat", 1, 8, 1);
        send_pattern("t$", 0, 1'b0);
        lit("tail_t", 1, 6, 2);
        send_pattern("^$", 0, 1'b0);
        lit("anchors_only", 0, 0, 0);
        send_pattern("c.t", 0, 1'b0);
        lit("wildcard", 1, 4, 1);
        send_pattern("dog", 0, 1'b1);
        lit("miss_dog", 0, 0, 0);
        chk("latency_slen11", last_valid_cyc - last_e_cyc, 12);

        s = "";
        for (int i = 0; i < 60; i++) s = {s, "a"};
        s = {s, "PQRSTUVWXY"};
        send_string(s);
        chk("ovf_long_string", int'(ovf), 1);
        send_pattern("PQRS", 0, 1'b0);
        lit("ovf_tail_chars", 1, 60, 1);
        send_pattern("S$", 0, 1'b0);
        lit("ovf_slen64", 1, 63, 1);
        send_pattern("U", 0, 1'b0);
        lit("ovf_dropped", 0, 0, 0);

        send_string("the cat sat");
        send_pattern("at", 3, 1'b0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_ovf", int'(ovf), 0);
        send_string("ab");
        send_pattern("b$", 0, 1'b0);
        lit("after_reset", 1, 1, 1);

        alpha_s = "ab ";
        alpha_p = "ab.";
        for (int it = 0; it < 40; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0) begin
                s   = "";
                len = $urandom_range(1, 70);
                for (int i = 0; i < len; i++) begin
                    r = $urandom_range(0, 2);
                    s = {s, alpha_s.substr(r, r)};
                end
                send_string(s);
            end
            p = "";
            if ($urandom_range(0, 2) == 0) p = "^";
            len = $urandom_range(0, 17);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 2);
                p = {p, alpha_p.substr(r, r)};
            end
            if ($urandom_range(0, 2) == 0) p = {p, "$"};
            if (p.len() == 0) p = "a";
            send_pattern(p, 0, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
